// File: rtl/hit_detect_multi.sv
// hit_detect_multi
//   Compares one marker position against N_TARGETS target boxes every clock.
//   Each channel debounces overlap for HOLD_CYCLES cycles, latches a hit until
//   the consumer acknowledges it, then cools down. After cooldown the marker
//   must leave the box before the channel can arm again.
//
// Ports
//   clk            system clock, rising edge
//   resetn         synchronous reset, ACTIVE HIGH despite the name
//   targetCoord_X  packed target X centres, channel i at [i*COORD_W +: COORD_W]
//   targetCoord_Y  packed target Y centres
//   targetSize     packed per-target half-size, channel i at [i*SIZE_W +: SIZE_W]
//   targetValid    per-channel enable (0 = target absent)
//   markerCoord_X  marker X
//   markerCoord_Y  marker Y
//   markerValid    marker position valid this cycle
//   hitAck         per-channel acknowledge, only honoured while the hit is latched
//   hit            registered per-channel hit flags
//   hitAny         OR of hit
//   hitId          lowest channel index with hit set, 0 when none
//   hitCount       packed per-channel saturating hit counters (CNT_W each)
//
// Build option
//   HIT_DETECT_COUNT_EN  when defined, per-channel hit counters are built;
//                        otherwise hitCount is tied to zero.

module hit_detect_lane #(
   parameter int COORD_W         = 12,
   parameter int SIZE_W          = 8,
   parameter int HOLD_CYCLES     = 4,
   parameter int COOLDOWN_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [COORD_W-1:0] targetX,
   input  logic [COORD_W-1:0] targetY,
   input  logic [SIZE_W-1:0]  size,
   input  logic               targetValid,
   input  logic [COORD_W-1:0] markerX,
   input  logic [COORD_W-1:0] markerY,
   input  logic               markerValid,
   input  logic               ack,
   output logic               hit,
   output logic [CNT_W-1:0]   hitCount
);
   localparam int MAXC = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, ARM, HIT, COOLDOWN} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [COORD_W-1:0] dX, dY, sizeExt;
   logic               overlap, enterHit;

   // Larger minus smaller, so the distance never wraps.
   always_comb begin
      dX      = (targetX >= markerX) ? (targetX - markerX) : (markerX - targetX);
      dY      = (targetY >= markerY) ? (targetY - markerY) : (markerY - targetY);
      sizeExt = COORD_W'(size);
   end

   // Strict compare: a zero half-size can never overlap.
   assign overlap = markerValid & targetValid & (dX < sizeExt) & (dY < sizeExt);

   // Transition into HIT from the debounce states; shared by FSM and counter.
   assign enterHit = overlap & (((state == IDLE) && (HOLD_CYCLES == 1)) ||
                                ((state == ARM) && (cnt == CW'(HOLD_CYCLES - 1))));

   always_ff @(posedge clk) begin
      if (resetn) begin
         state <= IDLE;
         cnt   <= '0;
         hit   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enterHit) begin
                  state <= HIT;
                  cnt   <= CW'(1);
                  hit   <= 1'b1;
               end else if (overlap) begin
                  state <= ARM;
                  cnt   <= CW'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            ARM: begin
               if (!overlap) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (enterHit) begin
                  state <= HIT;
                  hit   <= 1'b1;
               end else begin
                  cnt   <= cnt + CW'(1);
               end
            end
            // Latched until acked; losing overlap or targetValid does not clear it.
            HIT: begin
               if (ack) begin
                  state <= COOLDOWN;
                  cnt   <= '0;
                  hit   <= 1'b0;
               end
            end
            COOLDOWN: begin
               if (!targetValid) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if ((cnt >= CW'(COOLDOWN_CYCLES)) && !overlap) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt < CW'(COOLDOWN_CYCLES)) begin
                  cnt   <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               hit   <= 1'b0;
            end
         endcase
      end
   end

`ifdef HIT_DETECT_COUNT_EN
   logic [CNT_W-1:0] hitCnt;

   // Saturates at all-ones; only reset clears it.
   always_ff @(posedge clk) begin
      if (resetn)
         hitCnt <= '0;
      else if (enterHit && (hitCnt != '1))
         hitCnt <= hitCnt + CNT_W'(1);
   end

   assign hitCount = hitCnt;
`else
   assign hitCount = '0;
`endif

endmodule

module hit_detect_multi #(
   parameter int N_TARGETS       = 4,
   parameter int COORD_W         = 12,
   parameter int SIZE_W          = 8,
   parameter int HOLD_CYCLES     = 4,
   parameter int COOLDOWN_CYCLES = 16,
   parameter int CNT_W           = 8,
   localparam int ID_W           = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [N_TARGETS*COORD_W-1:0]   targetCoord_X,
   input  logic [N_TARGETS*COORD_W-1:0]   targetCoord_Y,
   input  logic [N_TARGETS*SIZE_W-1:0]    targetSize,
   input  logic [N_TARGETS-1:0]           targetValid,
   input  logic [COORD_W-1:0]             markerCoord_X,
   input  logic [COORD_W-1:0]             markerCoord_Y,
   input  logic                           markerValid,
   input  logic [N_TARGETS-1:0]           hitAck,
   output logic [N_TARGETS-1:0]           hit,
   output logic                           hitAny,
   output logic [ID_W-1:0]                hitId,
   output logic [N_TARGETS*CNT_W-1:0]     hitCount
);

   for (genvar i = 0; i < N_TARGETS; i++) begin : gLane
      hit_detect_lane #(
         .COORD_W         (COORD_W),
         .SIZE_W          (SIZE_W),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
         .CNT_W           (CNT_W)
      ) uLane (
         .clk         (clk),
         .resetn      (resetn),
         .targetX     (targetCoord_X[i*COORD_W +: COORD_W]),
         .targetY     (targetCoord_Y[i*COORD_W +: COORD_W]),
         .size        (targetSize[i*SIZE_W +: SIZE_W]),
         .targetValid (targetValid[i]),
         .markerX     (markerCoord_X),
         .markerY     (markerCoord_Y),
         .markerValid (markerValid),
         .ack         (hitAck[i]),
         .hit         (hit[i]),
         .hitCount    (hitCount[i*CNT_W +: CNT_W])
      );
   end

   assign hitAny = |hit;

   // Scan high to low so the lowest set index wins.
   always_comb begin
      hitId = '0;
      for (int i = N_TARGETS - 1; i >= 0; i--)
         if (hit[i]) hitId = ID_W'(i);
   end

endmodule

// File: tb/tb_hit_detect_multi.sv
module tb_hit_detect_multi;
   localparam int N = 4, CW = 12, SW = 8, HOLD = 4, COOL = 16, CNTW = 2, IDW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                resetn;
   logic [N*CW-1:0]     tX, tY;
   logic [N*SW-1:0]     tS;
   logic [N-1:0]        tv, ack, hit;
   logic [CW-1:0]       mx, my;
   logic                mv, hitAny;
   logic [IDW-1:0]      hitId;
   logic [N*CNTW-1:0]   hitCount;

   int total = 0, bad = 0;

   // Reference model: 0 = ready (counting overlap run), 1 = latched, 2 = cooling
   int mSt[N], run[N], cool[N], hits[N];

   hit_detect_multi #(.N_TARGETS(N), .COORD_W(CW), .SIZE_W(SW), .HOLD_CYCLES(HOLD),
                      .COOLDOWN_CYCLES(COOL), .CNT_W(CNTW)) dut (
      .clk(clk), .resetn(resetn), .targetCoord_X(tX), .targetCoord_Y(tY), .targetSize(tS),
      .targetValid(tv), .markerCoord_X(mx), .markerCoord_Y(my), .markerValid(mv),
      .hitAck(ack), .hit(hit), .hitAny(hitAny), .hitId(hitId), .hitCount(hitCount));

   task automatic setTarget(input int i, input int x, input int y, input int s);
      tX[i*CW +: CW] = CW'(x);
      tY[i*CW +: CW] = CW'(y);
      tS[i*SW +: SW] = SW'(s);
   endtask

   task automatic setMarker(input int x, input int y);
      mx = CW'(x);
      my = CW'(y);
   endtask

   function automatic int modelOv(input int i);
      int dx, dy, s;
      if (!mv || !tv[i]) return 0;
      dx = int'(tX[i*CW +: CW]) - int'(mx);
      dy = int'(tY[i*CW +: CW]) - int'(my);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      s = int'(tS[i*SW +: SW]);
      return (dx < s && dy < s) ? 1 : 0;
   endfunction

   function automatic int expCount(input int i);
`ifdef HIT_DETECT_COUNT_EN
      return (hits[i] > 3) ? 3 : hits[i];
`else
      return 0;
`endif
   endfunction

   // One clock: model advances with the inputs held across the edge, then
   // outputs are sampled 1 time unit later.
   task automatic tick();
      int ov[N];
      for (int i = 0; i < N; i++) ov[i] = modelOv(i);
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (resetn) begin
            mSt[i] = 0; run[i] = 0; cool[i] = 0; hits[i] = 0;
         end else if (mSt[i] == 0) begin
            run[i] = ov[i] ? run[i] + 1 : 0;
            if (run[i] >= HOLD) begin mSt[i] = 1; run[i] = 0; hits[i]++; end
         end else if (mSt[i] == 1) begin
            if (ack[i]) begin mSt[i] = 2; cool[i] = 0; end
         end else begin
            if (!tv[i]) begin mSt[i] = 0; run[i] = 0; end
            else if (cool[i] >= COOL && !ov[i]) begin mSt[i] = 0; run[i] = 0; end
            else if (cool[i] < COOL) cool[i]++;
         end
      end
      #1;
   endtask

   // Stimulus-only cleanup: ack everything, move marker away, let cooldown expire.
   task automatic clear_all();
      ack = '1;
      setMarker(2000, 2000);
      tick();
      ack = '0;
      repeat (20) tick();
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      repeat (2) tick();
      total++; if (hit !== 4'b0000) begin bad++; $display("FAIL reset_hit got=%b want=0000", hit); end
      total++; if (hitAny !== 1'b0) begin bad++; $display("FAIL reset_hitAny got=%b want=0", hitAny); end
      total++; if (hitId !== 2'd0) begin bad++; $display("FAIL reset_hitId got=%0d want=0", hitId); end
      total++; if (hitCount !== '0) begin bad++; $display("FAIL reset_hitCount got=%h want=0", hitCount); end
      resetn = 1'b0;
   endtask

   task automatic test_basic();
      int seen;
      tv = 4'b0001;
      setTarget(0, 100, 100, 50);
      setMarker(120, 80);
      mv = 1'b1;
      for (int c = 1; c <= HOLD; c++) begin
         tick();
         total++;
         if (hit[0] !== (c == HOLD)) begin
            bad++; $display("FAIL basic_latency cycle=%0d got=%b want=%b", c, hit[0], (c == HOLD));
         end
      end
      total++; if (hitId !== 2'd0) begin bad++; $display("FAIL basic_hitId got=%0d want=0", hitId); end
      total++; if (hitAny !== 1'b1) begin bad++; $display("FAIL basic_hitAny got=%b want=1", hitAny); end
      ack[0] = 1'b1;
      setMarker(150, 100);           // dX == size: must never overlap
      tick();
      ack = '0;
      total++; if (hit !== 4'b0000) begin bad++; $display("FAIL basic_ack got=%b want=0000", hit); end
      seen = 0;
      repeat (30) begin tick(); if (hit !== 4'b0000) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL basic_edge_nohit cycles_hit=%0d want=0", seen); end
   endtask

   task automatic test_burst();
      int seen;
      seen = 0;
      setMarker(120, 80);
      repeat (3) begin tick(); if (hit[0]) seen++; end
      setMarker(300, 300);
      tick(); if (hit[0]) seen++;
      total++; if (seen != 0) begin bad++; $display("FAIL burst_short cycles_hit=%0d want=0", seen); end
      setMarker(120, 80);
      for (int c = 1; c <= HOLD; c++) begin
         tick();
         total++;
         if (hit[0] !== (c == HOLD)) begin
            bad++; $display("FAIL burst_second cycle=%0d got=%b want=%b", c, hit[0], (c == HOLD));
         end
      end
      clear_all();
   endtask

   task automatic test_latch_ack();
      int seen;
      setMarker(120, 80);
      repeat (HOLD) tick();
      total++; if (hit[0] !== 1'b1) begin bad++; $display("FAIL latch_set got=%b want=1", hit[0]); end
      setMarker(300, 300);
      seen = 0;
      repeat (100) begin tick(); if (hit[0] !== 1'b1) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL latch_hold cycles_low=%0d want=0", seen); end
      setMarker(120, 80);
      ack[0] = 1'b1;
      tick();
      ack = '0;
      total++; if (hit[0] !== 1'b0) begin bad++; $display("FAIL latch_ack got=%b want=0", hit[0]); end
      seen = 0;
      repeat (30) begin tick(); if (hit[0]) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL cooldown_stay_inside cycles_hit=%0d want=0", seen); end
      setMarker(300, 300);
      tick();
      setMarker(120, 80);
      seen = 0;
      repeat (HOLD - 1) begin tick(); if (hit[0]) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL rearm_early cycles_hit=%0d want=0", seen); end
      tick();
      total++; if (hit[0] !== 1'b1) begin bad++; $display("FAIL rearm_hit got=%b want=1", hit[0]); end
      clear_all();
   endtask

   task automatic test_multi();
      tv = 4'b1010;
      setTarget(1, 300, 300, 40);
      setTarget(3, 300, 300, 40);
      setMarker(310, 290);
      repeat (HOLD) tick();
      total++; if (hit !== 4'b1010) begin bad++; $display("FAIL multi_hit got=%b want=1010", hit); end
      total++; if (hitId !== 2'd1) begin bad++; $display("FAIL multi_hitId got=%0d want=1", hitId); end
      ack = 4'b0010;
      tick();
      ack = '0;
      total++; if (hit !== 4'b1000) begin bad++; $display("FAIL multi_ack1 got=%b want=1000", hit); end
      total++; if (hitId !== 2'd3) begin bad++; $display("FAIL multi_hitId3 got=%0d want=3", hitId); end
      clear_all();
   endtask

   task automatic test_reset_mid();
      int seen;
      tv = 4'b0100;
      setTarget(2, 100, 100, 50);
      setMarker(120, 80);
      repeat (HOLD) tick();
      total++; if (hit !== 4'b0100) begin bad++; $display("FAIL rstmid_pre got=%b want=0100", hit); end
      tv = 4'b0101;
      repeat (2) tick();             // ch0 now two cycles into arming
      total++; if (hit !== 4'b0100) begin bad++; $display("FAIL rstmid_arm got=%b want=0100", hit); end
      resetn = 1'b1;
      ack = 4'b0100;                 // reset must dominate ack
      tick();
      resetn = 1'b0;
      ack = '0;
      total++; if ({hit, hitAny, hitId} !== '0) begin
         bad++; $display("FAIL rstmid_out hit=%b any=%b id=%0d want=all0", hit, hitAny, hitId);
      end
      total++; if (hitCount !== '0) begin bad++; $display("FAIL rstmid_count got=%h want=0", hitCount); end
      seen = 0;
      repeat (HOLD - 1) begin tick(); if (hit !== 4'b0000) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL rstmid_rearm_early cycles_hit=%0d want=0", seen); end
      tick();
      total++; if (hit !== 4'b0101) begin bad++; $display("FAIL rstmid_rearm got=%b want=0101", hit); end
      clear_all();
   endtask

   task automatic test_count();
      int exp;
      resetn = 1'b1; tick(); resetn = 1'b0;
      tv = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         setMarker(120, 80);
         repeat (HOLD) tick();
         ack[0] = 1'b1;
         setMarker(300, 300);
         tick();
         ack = '0;
         repeat (17) tick();
         if (k == 2 || k == 5) begin
`ifdef HIT_DETECT_COUNT_EN
            exp = (k == 2) ? 2 : 3;
`else
            exp = 0;
`endif
            total++;
            if (int'(hitCount[CNTW-1:0]) != exp) begin
               bad++; $display("FAIL count_after_%0d got=%0d want=%0d", k, hitCount[CNTW-1:0], exp);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0] expHit;
      int expId, printed, t;
      printed = 0;
      resetn = 1'b1; tick(); resetn = 1'b0;
      for (int i = 0; i < N; i++)
         setTarget(i, $urandom_range(300, 50), $urandom_range(300, 50), $urandom_range(80, 0));
      tv = 4'($urandom);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7, 0) == 0) begin
            if ($urandom_range(1, 0) == 0) begin
               t = $urandom_range(N - 1, 0);
               setMarker(int'(tX[t*CW +: CW]) + $urandom_range(120, 0) - 60,
                         int'(tY[t*CW +: CW]) + $urandom_range(120, 0) - 60);
            end else begin
               setMarker($urandom_range(400, 0), $urandom_range(400, 0));
            end
         end
         mv = ($urandom_range(15, 0) != 0);
         for (int i = 0; i < N; i++) begin
            ack[i] = ($urandom_range(7, 0) == 0);
            if ($urandom_range(63, 0) == 0) tv[i] = ~tv[i];
         end
         if ($urandom_range(199, 0) == 0) begin
            t = $urandom_range(N - 1, 0);
            setTarget(t, $urandom_range(300, 50), $urandom_range(300, 50), $urandom_range(80, 0));
         end
         resetn = ($urandom_range(499, 0) == 0);
         tick();
         expHit = '0;
         expId = 0;
         for (int i = N - 1; i >= 0; i--) if (mSt[i] == 1) begin expHit[i] = 1'b1; expId = i; end
         total++;
         if (hit !== expHit || hitAny !== (|expHit) || int'(hitId) != expId) begin
            bad++;
            if (printed < 10) begin
               printed++;
               $display("FAIL rand_hit cycle=%0d got hit=%b any=%b id=%0d want hit=%b any=%b id=%0d",
                        c, hit, hitAny, hitId, expHit, |expHit, expId);
            end
         end
         for (int i = 0; i < N; i++) begin
            total++;
            if (int'(hitCount[i*CNTW +: CNTW]) != expCount(i)) begin
               bad++;
               if (printed < 10) begin
                  printed++;
                  $display("FAIL rand_count cycle=%0d ch=%0d got=%0d want=%0d",
                           c, i, hitCount[i*CNTW +: CNTW], expCount(i));
               end
            end
         end
      end
      resetn = 1'b0;
   endtask

   initial begin
      resetn = 1'b1;
      tX = '0; tY = '0; tS = '0; tv = '0; ack = '0;
      mx = '0; my = '0; mv = 1'b0;
      test_reset();
      test_basic();
      test_burst();
      test_latch_ack();
      test_multi();
      test_reset_mid();
      test_count();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
